// File: rtl/c3lib_ckg_ctrl.sv
// Demand-driven clock-gating controller: req/ack wake handshake, idle hysteresis,
// gated-off cycle telemetry and an integrated glitch-free ICG cell.

module c3lib_ckg_lvt_8x (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic gated_clk
);

  logic en_lat;

  // Transparent while clk is low so the AND below can only open on a full high phase.
  always_latch begin
    if (!clk) en_lat = en | te;
  end

  assign gated_clk = clk & en_lat;

endmodule

module c3lib_ckg_ctrl #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  input  logic               force_on,
  input  logic               tst_en,
  input  logic               cnt_clr,
  output logic               clk_en,
  output logic               gated_clk,
  output logic [CNT_W-1:0]   gated_cyc_cnt
);

  localparam int unsigned MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t               state, next_state;
  logic [CW-1:0]        cnt, next_cnt;
  logic                 any;
  logic                 clk_en_d;
  logic [NUM_REQ-1:0]   ack_d;

  assign any = (|req) | force_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      OFF: begin
        if (any) begin
          next_state = WAKE;
          next_cnt   = WAKE_LD;
        end
      end
      // WAKE always runs its full settle time, even if every request has dropped.
      WAKE: begin
        if (cnt != '0) begin
          next_cnt = cnt - 1'b1;
        end else if (any) begin
          next_state = ON;
        end else begin
          next_state = HOLD;
          next_cnt   = IDLE_LD;
        end
      end
      ON: begin
        if (!any) begin
          next_state = HOLD;
          next_cnt   = IDLE_LD;
        end
      end
      HOLD: begin
        if (any) begin
          next_state = ON;
        end else if (cnt != '0) begin
          next_cnt = cnt - 1'b1;
        end else begin
          next_state = OFF;
        end
      end
      default: begin
        next_state = OFF;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    clk_en_d = (next_state != OFF);
    ack_d    = (next_state == ON) ? req : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_en <= 1'b0;
      ack    <= '0;
    end else begin
      clk_en <= clk_en_d;
      ack    <= ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cyc_cnt <= '0;
    end else if (cnt_clr) begin
      gated_cyc_cnt <= '0;
    end else if (!clk_en && (gated_cyc_cnt != '1)) begin
      gated_cyc_cnt <= gated_cyc_cnt + CNT_W'(1);
    end
  end

  c3lib_ckg_lvt_8x u_icg (
    .clk       (clk),
    .en        (clk_en),
    .te        (tst_en),
    .gated_clk (gated_clk)
  );

endmodule

// File: tb/tb_c3lib_ckg_ctrl.sv
// Scoreboard bench for c3lib_ckg_ctrl: a cycle model predicts ack, clk_en,
// gated_clk and the telemetry counter for every driven cycle.

module tb_c3lib_ckg_ctrl;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned WAKE_CYC = 2;
  localparam int unsigned IDLE_CYC = 16;
  localparam int unsigned CNT_W    = 8;

  localparam int S_OFF  = 0;
  localparam int S_WAKE = 1;
  localparam int S_ON   = 2;
  localparam int S_HOLD = 3;

  logic               clk;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               force_on;
  logic               tst_en;
  logic               cnt_clr;
  logic               clk_en;
  logic               gated_clk;
  logic [CNT_W-1:0]   gated_cyc_cnt;

  c3lib_ckg_ctrl #(
    .NUM_REQ  (NUM_REQ),
    .WAKE_CYC (WAKE_CYC),
    .IDLE_CYC (IDLE_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .ack           (ack),
    .force_on      (force_on),
    .tst_en        (tst_en),
    .cnt_clr       (cnt_clr),
    .clk_en        (clk_en),
    .gated_clk     (gated_clk),
    .gated_cyc_cnt (gated_cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] ack;
    logic               en;
    int                 cnt;
    logic               gclk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   glitch_cnt = 0;

  // Reference model state
  int                 m_st;
  int                 m_left;
  logic               m_en;
  logic [NUM_REQ-1:0] m_ack;
  int                 m_cnt;

  always @(posedge gated_clk) if (!clk) glitch_cnt++;
  always @(negedge gated_clk) if (clk) glitch_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = S_OFF;
    m_left = 0;
    m_en   = 1'b0;
    m_ack  = '0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [NUM_REQ-1:0] r, input logic f, input logic c);
    bit any;
    int max_cnt;
    any     = (|r) || f;
    max_cnt = (1 << CNT_W) - 1;
    if (c) m_cnt = 0;
    else if (!m_en && m_cnt < max_cnt) m_cnt = m_cnt + 1;
    case (m_st)
      S_OFF:  if (any) begin m_st = S_WAKE; m_left = WAKE_CYC - 1; end
      S_WAKE: begin
        if (m_left > 0) m_left = m_left - 1;
        else if (any) m_st = S_ON;
        else begin m_st = S_HOLD; m_left = IDLE_CYC - 1; end
      end
      S_ON:   if (!any) begin m_st = S_HOLD; m_left = IDLE_CYC - 1; end
      default: begin
        if (any) m_st = S_ON;
        else if (m_left > 0) m_left = m_left - 1;
        else m_st = S_OFF;
      end
    endcase
    m_en  = (m_st != S_OFF);
    m_ack = (m_st == S_ON) ? r : '0;
  endtask

  // Called in the clock low phase; returns at the following negedge.
  task automatic cyc(input logic [NUM_REQ-1:0] r, input logic f, input logic c, input logic t);
    exp_t e;
    exp_t got;
    logic old_en;
    req      = r;
    force_on = f;
    cnt_clr  = c;
    tst_en   = t;
    old_en   = m_en;
    model_step(r, f, c);
    e.ack  = m_ack;
    e.en   = m_en;
    e.cnt  = m_cnt;
    e.gclk = old_en | t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("ack", 32'(ack), 32'(got.ack));
      check("clk_en", 32'(clk_en), 32'(got.en));
      check("gated_cyc_cnt", 32'(gated_cyc_cnt), got.cnt);
      check("gated_clk_high", 32'(gated_clk), 32'(got.gclk));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] rr;
    logic               rf, rc, rt;
    int                 hold;

    rst_n    = 1'b0;
    req      = '0;
    force_on = 1'b0;
    tst_en   = 1'b0;
    cnt_clr  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_cnt", 32'(gated_cyc_cnt), 32'd0);
    rst_n = 1'b1;

    // Idle after reset: counter runs 1,2,3...
    idle(5);
    check("idle_cnt5", 32'(gated_cyc_cnt), 32'd5);

    // Wake latency from OFF
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    check("wake_en_edge0", 32'(clk_en), 32'd1);
    check("wake_ack_edge0", 32'(ack), 32'd0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    check("wake_ack_edge1", 32'(ack), 32'd0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    check("wake_ack_edge2", 32'(ack), 32'd1);
    repeat (3) cyc(4'b0001, 1'b0, 1'b0, 1'b0);

    // Hysteresis: ack drops next cycle, clk_en held for IDLE_CYC cycles
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("hyst_ack_drop", 32'(ack), 32'd0);
    idle(IDLE_CYC - 1);
    check("hyst_en_last", 32'(clk_en), 32'd1);
    idle(1);
    check("hyst_en_off", 32'(clk_en), 32'd0);
    idle(3);

    // Re-request during HOLD
    repeat (4) cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    idle(5);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    check("rereq_ack2", 32'(ack), 32'h4);
    repeat (3) cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    idle(IDLE_CYC + 3);

    // Multi requesters, then force_on alone
    repeat (5) cyc(4'b1010, 1'b0, 1'b0, 1'b0);
    check("multi_ack", 32'(ack), 32'ha);
    repeat (6) cyc('0, 1'b1, 1'b0, 1'b0);
    check("force_en", 32'(clk_en), 32'd1);
    idle(IDLE_CYC + 3);
    check("force_off", 32'(clk_en), 32'd0);

    // One-cycle pulse: full WAKE then HOLD, never acked
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    idle(WAKE_CYC + IDLE_CYC + 3);

    // Asynchronous reset while ON
    repeat (5) cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_clk_en", 32'(clk_en), 32'd0);
    check("midrst_cnt", 32'(gated_cyc_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_gclk", 32'(gated_clk), 32'd0);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    idle(3);

    // Saturation, clear priority, restart
    idle((1 << CNT_W) + 5);
    check("sat_cnt", 32'(gated_cyc_cnt), 32'hff);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("clr_zero", 32'(gated_cyc_cnt), 32'd0);
    idle(1);
    check("clr_then_one", 32'(gated_cyc_cnt), 32'd1);

    // Scan enable in OFF: clock passes through, state untouched
    repeat (6) cyc('0, 1'b0, 1'b0, 1'b1);
    check("tst_en_stays_off", 32'(clk_en), 32'd0);
    idle(2);

    // Random traffic held for random lengths
    for (int k = 0; k < 40; k++) begin
      rr   = ($urandom_range(0, 2) == 0) ? '0 : NUM_REQ'($urandom_range(0, 15));
      rf   = ($urandom_range(0, 7) == 0);
      rc   = ($urandom_range(0, 9) == 0);
      rt   = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(1, 22);
      for (int j = 0; j < hold; j++) cyc(rr, rf, rc && (j == 0), rt);
    end
    idle(IDLE_CYC + WAKE_CYC + 2);

    check("glitches", 32'(glitch_cnt), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
